// File: rtl/dma_rd_burst_ring.sv
// Read DMA engine: issues boundary-aligned read bursts under FIFO credit
// control, buffers returned beats in a show-ahead FIFO and streams them out
// with an end-of-pass flag. Supports ring (repeat) mode and abort.
module dma_rd_burst_ring #(
    parameter int AW = 32,
    parameter int AL = 2,
    parameter int DW = 8 * (2 ** AL),
    parameter int BL = 3,
    parameter int LW = 24,
    parameter int FD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pio_adr_we,
    input  logic          pio_len_we,
    input  logic          pio_ctl_we,
    input  logic [31:0]   pio_d,
    output logic [AW-1:0] pio_adr,
    output logic [LW-1:0] pio_len,
    output logic          busy,
    output logic          dma_done,
    output logic          dma_err,
    input  logic          dma_rdy,
    output logic          dma_val,
    output logic          dma_eof,
    output logic [DW-1:0] dma_d,
    input  logic          bus_rrdy,
    output logic          bus_rval,
    output logic [BL:0]   bus_rlen,
    output logic [AW-1:0] bus_raddr,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_rdval
);

    localparam int RW = LW - AL;   // length counted in beats
    localparam int CW = FD + 1;    // FIFO occupancy / outstanding counters
    localparam int BW = BL + 1;    // burst length field
    localparam logic [BW-1:0] BMAX = BW'(2 ** BL);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_adr, adr;
    logic [RW-1:0] base_beats, rem, ret_cnt;
    logic          ring, hold_q, abort_q;
    logic [BW-1:0] bmax;
    logic [CW-1:0] outst, fcnt;
    logic [FD-1:0] wr_ptr, rd_ptr;
    logic [DW:0]   mem [2**FD];
    logic [DW:0]   head;

    logic [RW-1:0] len_beats;
    logic [BW-1:0] ctl_bmax, bmax_new, to_bnd, rem_c, bc;
    logic [CW:0]   need, free;
    logic          credit_ok, abort_wr, abort_now, push, pop, eof_in;
    logic          accept, reload, done_d, err_d;
    logic          unused_bits;

    assign unused_bits = ^pio_d;

    assign len_beats = pio_d[LW-1:AL];
    assign ctl_bmax  = pio_d[BL+4:4];
    assign bmax_new  = (ctl_bmax == '0 || ctl_bmax > BMAX) ? BMAX : ctl_bmax;
    assign abort_wr  = pio_ctl_we & pio_d[1];
    // abort acts in the very cycle it is written, not only once registered
    assign abort_now = abort_q | (abort_wr & (state_q != IDLE));

    // burst size: smallest of programmed max, remaining beats, beats to boundary
    always_comb begin
        to_bnd = BMAX - BW'(adr[BL+AL-1:AL]);
        rem_c  = (rem >= RW'(BMAX)) ? BMAX : rem[BW-1:0];
        bc     = bmax;
        if (rem_c < bc)  bc = rem_c;
        if (to_bnd < bc) bc = to_bnd;
    end

    // a request is only raised when everything in flight plus this burst fits
    assign need      = {1'b0, outst} + (CW+1)'(bc);
    assign free      = (CW+1)'(2 ** FD) - {1'b0, fcnt};
    assign credit_ok = free >= need;

    // beats arriving with nothing outstanding (e.g. after reset) are dropped
    assign push   = bus_rdval & (outst != '0);
    assign pop    = dma_val & dma_rdy;
    assign eof_in = ~abort_now & (ret_cnt == RW'(1));

    assign head      = mem[rd_ptr];
    assign dma_val   = fcnt != '0;
    assign dma_eof   = dma_val & head[DW];
    assign dma_d     = dma_val ? head[DW-1:0] : '0;
    assign busy      = state_q != IDLE;
    assign pio_adr   = adr;
    assign pio_len   = {rem, {AL{1'b0}}};
    assign bus_raddr = bus_rval ? adr : '0;
    assign bus_rlen  = bus_rval ? bc : '0;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state, bus request and completion pulses
    always_comb begin
        state_d  = state_q;
        bus_rval = 1'b0;
        accept   = 1'b0;
        reload   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pio_len_we) begin
                    if (len_beats == '0) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // once raised, a request is held until taken, even across abort
                bus_rval = hold_q | (~abort_now & credit_ok);
                accept   = bus_rval & bus_rrdy;
                if ((accept && (rem == RW'(bc) || abort_now)) || (abort_now && !bus_rval))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (outst == '0) begin
                    done_d = 1'b1;
                    err_d  = abort_now;
                    if (ring && !abort_now) begin
                        reload  = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // programming registers, address/length walk and in-flight accounting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_adr   <= '0;
            adr        <= '0;
            base_beats <= '0;
            rem        <= '0;
            ret_cnt    <= '0;
            ring       <= 1'b0;
            bmax       <= BMAX;
            hold_q     <= 1'b0;
            abort_q    <= 1'b0;
            outst      <= '0;
            dma_done   <= 1'b0;
            dma_err    <= 1'b0;
        end else begin
            dma_done <= done_d;
            dma_err  <= err_d;
            hold_q   <= bus_rval & ~bus_rrdy;
            outst    <= outst + (accept ? CW'(bc) : '0) - CW'(push);

            if (state_d == IDLE)                  abort_q <= 1'b0;
            else if (abort_wr && state_q != IDLE) abort_q <= 1'b1;

            if (state_q == IDLE && pio_adr_we) begin
                base_adr <= {pio_d[AW-1:AL], {AL{1'b0}}};
                adr      <= {pio_d[AW-1:AL], {AL{1'b0}}};
            end else if (reload) begin
                adr <= base_adr;
            end else if (accept) begin
                adr <= adr + (AW'(bc) << AL);
            end

            if (state_q == IDLE && pio_len_we) begin
                base_beats <= len_beats;
                rem        <= len_beats;
            end else if (reload) begin
                rem <= base_beats;
            end else if (accept) begin
                rem <= rem - RW'(bc);
            end

            // eof is decided on return order, so count beats back, not requests
            if (state_q == IDLE && pio_len_we) ret_cnt <= len_beats;
            else if (reload)                   ret_cnt <= base_beats;
            else if (push && ret_cnt != '0)    ret_cnt <= ret_cnt - RW'(1);

            if (state_q == IDLE && pio_ctl_we) begin
                ring <= pio_d[0];
                bmax <= bmax_new;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FD'(1);
            if (pop)  rd_ptr <= rd_ptr + FD'(1);
            fcnt <= fcnt + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {eof_in, bus_rdata};
    end

endmodule

// File: tb/tb_dma_rd_burst_ring.sv
// Scoreboard bench for dma_rd_burst_ring: a bus responder returns a fixed
// address-derived data pattern, a monitor records bursts and output beats,
// and each test task compares them against bench-built expectations.
module tb_dma_rd_burst_ring;

    typedef logic [32:0] beat_t;   // {eof, data}
    typedef logic [35:0] burst_t;  // {addr, len}

    logic        clk, rst_n;
    logic        pio_adr_we, pio_len_we, pio_ctl_we;
    logic [31:0] pio_d, pio_adr;
    logic [23:0] pio_len;
    logic        busy, dma_done, dma_err, dma_rdy, dma_val, dma_eof;
    logic [31:0] dma_d;
    logic        bus_rrdy, bus_rval, bus_rdval;
    logic [3:0]  bus_rlen;
    logic [31:0] bus_raddr, bus_rdata;

    int vecs = 0;
    int miscmp = 0;

    logic [31:0] rd_q[$];
    beat_t       obs_beat_q[$], exp_beat_q[$];
    burst_t      obs_burst_q[$], exp_burst_q[$];
    int          req_beats, done_cnt, err_cnt, both_cnt;
    bit          stall_en, gap_en, rd_hold;

    dma_rd_burst_ring #(.FD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pio_adr_we(pio_adr_we), .pio_len_we(pio_len_we), .pio_ctl_we(pio_ctl_we),
        .pio_d(pio_d), .pio_adr(pio_adr), .pio_len(pio_len),
        .busy(busy), .dma_done(dma_done), .dma_err(dma_err),
        .dma_rdy(dma_rdy), .dma_val(dma_val), .dma_eof(dma_eof), .dma_d(dma_d),
        .bus_rrdy(bus_rrdy), .bus_rval(bus_rval), .bus_rlen(bus_rlen),
        .bus_raddr(bus_raddr), .bus_rdata(bus_rdata), .bus_rdval(bus_rdval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // bus responder and output monitor, active between clock edges
    initial begin
        bus_rrdy  = 1'b0;
        bus_rdval = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            bus_rrdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rd_q.size() > 0 && !rd_hold && (!gap_en || $urandom_range(0, 2) != 0)) begin
                bus_rdval = 1'b1;
                bus_rdata = mdata(rd_q.pop_front());
            end else begin
                bus_rdval = 1'b0;
                bus_rdata = '0;
            end
            #1;
            if (bus_rval && bus_rrdy) begin
                obs_burst_q.push_back({bus_raddr, bus_rlen});
                for (int i = 0; i < int'(bus_rlen); i++) rd_q.push_back(bus_raddr + 32'(4 * i));
                req_beats += int'(bus_rlen);
            end
            if (dma_val && dma_rdy) obs_beat_q.push_back({dma_eof, dma_d});
            if (dma_done) done_cnt++;
            if (dma_err) err_cnt++;
            if (dma_done && dma_err) both_cnt++;
        end
    end

    task automatic clear_sb();
        obs_beat_q.delete(); exp_beat_q.delete();
        obs_burst_q.delete(); exp_burst_q.delete();
        req_beats = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    endtask

    // kind: 0 address, 1 length, 2 control; returns at the following negedge
    task automatic pio_write(input int kind, input logic [31:0] d);
        pio_d      = d;
        pio_adr_we = (kind == 0);
        pio_len_we = (kind == 1);
        pio_ctl_we = (kind == 2);
        @(negedge clk);
        pio_adr_we = 1'b0;
        pio_len_we = 1'b0;
        pio_ctl_we = 1'b0;
        pio_d      = '0;
    endtask

    // reference split: max burst, remaining, and 32-byte boundary
    task automatic push_model(input logic [31:0] base, input int len, input int bm, input int passes);
        int a, r, b, n;
        n = len / 4;
        for (int p = 0; p < passes; p++) begin
            a = int'(base); r = n;
            while (r > 0) begin
                b = bm;
                if (r < b) b = r;
                if (8 - ((a / 4) % 8) < b) b = 8 - ((a / 4) % 8);
                exp_burst_q.push_back({32'(a), 4'(b)});
                a += 4 * b; r -= b;
            end
            for (int i = 0; i < n; i++)
                exp_beat_q.push_back({i == n - 1, mdata(base + 32'(4 * i))});
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy && !dma_val && rd_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        vecs++;
        if ({busy, dma_val, dma_eof, bus_rval, dma_done, dma_err} !== 6'b0) begin
            miscmp++;
            $display("FAIL reset_flags: got %b want 000000", {busy, dma_val, dma_eof, bus_rval, dma_done, dma_err});
        end
        vecs++;
        if ({pio_adr, pio_len} !== 56'h0) begin
            miscmp++; $display("FAIL reset_pio: got %h want 0", {pio_adr, pio_len});
        end
        vecs++;
        if ({bus_raddr, bus_rlen, dma_d} !== 68'h0) begin
            miscmp++; $display("FAIL reset_bus: got %h want 0", {bus_raddr, bus_rlen, dma_d});
        end
    endtask

    task automatic test_basic();
        bit ok;
        burst_t eb, ob;
        beat_t  e, o;
        clear_sb();
        dma_rdy = 1'b1; stall_en = 1'b0; gap_en = 1'b0;
        pio_write(0, 32'h100);
        pio_write(2, 32'h80);
        push_model(32'h100, 64, 8, 1);
        pio_write(1, 64);
        vecs++;
        if ({busy, bus_rval} !== 2'b11) begin
            miscmp++; $display("FAIL basic_rval_rise: got %b want 11", {busy, bus_rval});
        end
        wait_idle(300, ok);
        vecs++;
        if (!ok) begin miscmp++; $display("FAIL basic_timeout: got busy want idle"); end
        while (exp_burst_q.size() > 0) begin
            eb = exp_burst_q.pop_front(); vecs++;
            ob = (obs_burst_q.size() > 0) ? obs_burst_q.pop_front() : 'x;
            if (ob !== eb) begin miscmp++; $display("FAIL basic_burst: got %h want %h", ob, eb); end
        end
        while (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front(); vecs++;
            o = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
            if (o !== e) begin miscmp++; $display("FAIL basic_beat: got %h want %h", o, e); end
        end
        vecs++;
        if ({obs_burst_q.size(), obs_beat_q.size(), done_cnt, err_cnt} !== {32'd0, 32'd0, 32'd1, 32'd0}) begin
            miscmp++;
            $display("FAIL basic_counts: got extra_bursts=%0d extra_beats=%0d done=%0d err=%0d want 0 0 1 0",
                     obs_burst_q.size(), obs_beat_q.size(), done_cnt, err_cnt);
        end
    endtask

    task automatic test_boundary();
        bit ok;
        burst_t eb, ob;
        beat_t  e, o;
        clear_sb();
        dma_rdy = 1'b1; stall_en = 1'b1; gap_en = 1'b1;
        pio_write(0, 32'h11E);
        vecs++;
        if (pio_adr !== 32'h11C) begin
            miscmp++; $display("FAIL bnd_adr_align: got %h want 0000011c", pio_adr);
        end
        pio_write(2, 32'h80);
        exp_burst_q.push_back({32'h11C, 4'd1});
        exp_burst_q.push_back({32'h120, 4'd8});
        exp_burst_q.push_back({32'h140, 4'd1});
        for (int i = 0; i < 10; i++) exp_beat_q.push_back({i == 9, mdata(32'h11C + 32'(4 * i))});
        pio_write(1, 43);
        vecs++;
        if (pio_len !== 24'd40) begin
            miscmp++; $display("FAIL bnd_len_align: got %0d want 40", pio_len);
        end
        wait_idle(400, ok);
        vecs++;
        if (!ok) begin miscmp++; $display("FAIL bnd_timeout: got busy want idle"); end
        while (exp_burst_q.size() > 0) begin
            eb = exp_burst_q.pop_front(); vecs++;
            ob = (obs_burst_q.size() > 0) ? obs_burst_q.pop_front() : 'x;
            if (ob !== eb) begin miscmp++; $display("FAIL bnd_burst: got %h want %h", ob, eb); end
        end
        while (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front(); vecs++;
            o = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
            if (o !== e) begin miscmp++; $display("FAIL bnd_beat: got %h want %h", o, e); end
        end
        vecs++;
        if ({obs_beat_q.size(), done_cnt} !== {32'd0, 32'd1}) begin
            miscmp++; $display("FAIL bnd_counts: got extra=%0d done=%0d want 0 1", obs_beat_q.size(), done_cnt);
        end
        stall_en = 1'b0; gap_en = 1'b0;
    endtask

    task automatic test_credit();
        bit ok, over;
        burst_t eb, ob;
        beat_t  e, o;
        clear_sb();
        dma_rdy = 1'b0; stall_en = 1'b0; gap_en = 1'b0;
        pio_write(0, 32'h0);
        pio_write(2, 32'h0);  // burst max field 0 selects 8
        push_model(32'h0, 128, 8, 1);
        pio_write(1, 128);
        over = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (req_beats > 16) over = 1'b1;
        end
        vecs++;
        if (over) begin miscmp++; $display("FAIL credit_limit: got >16 want <=16 in flight"); end
        vecs++;
        if ({req_beats, 31'd0, bus_rval, 31'd0, dma_val} !== {32'd16, 32'd0, 32'd1}) begin
            miscmp++;
            $display("FAIL credit_stall: got req=%0d rval=%b val=%b want 16 0 1", req_beats, bus_rval, dma_val);
        end
        dma_rdy = 1'b1;
        ok = 1'b0; over = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_beats - obs_beat_q.size() > 16) over = 1'b1;
            if (!busy && !dma_val && rd_q.size() == 0) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok || over) begin
            miscmp++; $display("FAIL credit_drain: got ok=%b over=%b want 1 0", ok, over);
        end
        while (exp_burst_q.size() > 0) begin
            eb = exp_burst_q.pop_front(); vecs++;
            ob = (obs_burst_q.size() > 0) ? obs_burst_q.pop_front() : 'x;
            if (ob !== eb) begin miscmp++; $display("FAIL credit_burst: got %h want %h", ob, eb); end
        end
        while (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front(); vecs++;
            o = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
            if (o !== e) begin miscmp++; $display("FAIL credit_beat: got %h want %h", o, e); end
        end
    endtask

    task automatic test_ring_abort();
        bit ok;
        int n_extra;
        burst_t ob;
        beat_t  e, o;
        clear_sb();
        dma_rdy = 1'b1; stall_en = 1'b0; gap_en = 1'b0;
        pio_write(0, 32'h200);
        pio_write(2, 32'hF1);  // ring, burst max 15 clamps to 8
        push_model(32'h200, 32, 8, 3);
        pio_write(1, 32);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt >= 3) begin ok = 1'b1; break; end
        end
        vecs++;
        if (!ok) begin miscmp++; $display("FAIL ring_timeout: got done=%0d want 3", done_cnt); end
        pio_write(2, 32'h2);
        wait_idle(300, ok);
        vecs++;
        if (!ok) begin miscmp++; $display("FAIL abort_timeout: got busy want idle"); end
        while (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front(); vecs++;
            o = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
            if (o !== e) begin miscmp++; $display("FAIL ring_beat: got %h want %h", o, e); end
        end
        n_extra = obs_beat_q.size();
        for (int i = 0; i < n_extra; i++) begin
            o = obs_beat_q.pop_front(); vecs++;
            if (o !== {1'b0, mdata(32'h200 + 32'(4 * i))}) begin
                miscmp++; $display("FAIL abort_beat: got %h want %h", o, {1'b0, mdata(32'h200 + 32'(4 * i))});
            end
        end
        vecs++;
        if (n_extra > 8 || obs_burst_q.size() < 3 || obs_burst_q.size() > 4) begin
            miscmp++; $display("FAIL ring_sizes: got extra=%0d bursts=%0d want <=8 3..4", n_extra, obs_burst_q.size());
        end
        while (obs_burst_q.size() > 0) begin
            ob = obs_burst_q.pop_front(); vecs++;
            if (ob !== {32'h200, 4'd8}) begin miscmp++; $display("FAIL ring_burst: got %h want 0000200_8", ob); end
        end
        vecs++;
        if ({done_cnt, err_cnt, both_cnt} !== {32'd4, 32'd1, 32'd1}) begin
            miscmp++; $display("FAIL abort_pulses: got done=%0d err=%0d both=%0d want 4 1 1", done_cnt, err_cnt, both_cnt);
        end
    endtask

    task automatic test_zero_len();
        clear_sb();
        pio_write(2, 32'h80);
        pio_write(1, 0);
        vecs++;
        if ({dma_done, dma_err, busy, bus_rval} !== 4'b1100) begin
            miscmp++; $display("FAIL zero_len_pulse: got %b want 1100", {dma_done, dma_err, busy, bus_rval});
        end
        @(negedge clk);
        vecs++;
        if ({dma_done, dma_err, busy, bus_rval} !== 4'b0000) begin
            miscmp++; $display("FAIL zero_len_after: got %b want 0000", {dma_done, dma_err, busy, bus_rval});
        end
        vecs++;
        if (req_beats !== 0) begin miscmp++; $display("FAIL zero_len_req: got %0d want 0", req_beats); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_sb();
        dma_rdy = 1'b1; rd_hold = 1'b1;
        pio_write(2, 32'h80);
        pio_write(0, 32'h300);
        pio_write(1, 64);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_beats >= 8) begin ok = 1'b1; break; end
        end
        vecs++;
        if (!ok) begin miscmp++; $display("FAIL rstmid_req: got %0d want >=8", req_beats); end
        rst_n = 1'b0;
        @(negedge clk);
        vecs++;
        if ({busy, bus_rval, dma_val, dma_eof, dma_done, dma_err} !== 6'b0) begin
            miscmp++; $display("FAIL rstmid_flags: got %b want 000000", {busy, bus_rval, dma_val, dma_eof, dma_done, dma_err});
        end
        vecs++;
        if ({pio_adr, pio_len, bus_raddr, bus_rlen, dma_d} !== 124'h0) begin
            miscmp++; $display("FAIL rstmid_data: got %h want 0", {pio_adr, pio_len, bus_raddr, bus_rlen, dma_d});
        end
        rst_n = 1'b1;
        rd_hold = 1'b0;
        repeat (30) @(negedge clk);
        vecs++;
        if ({dma_val, busy} !== 2'b00 || obs_beat_q.size() !== 0 || rd_q.size() !== 0) begin
            miscmp++;
            $display("FAIL rstmid_late_rdval: got val=%b busy=%b beats=%0d pend=%0d want 0 0 0 0",
                     dma_val, busy, obs_beat_q.size(), rd_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pio_adr_we = 1'b0; pio_len_we = 1'b0; pio_ctl_we = 1'b0; pio_d = '0;
        dma_rdy = 1'b0; stall_en = 1'b0; gap_en = 1'b0; rd_hold = 1'b0;
        req_beats = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundary();
        test_credit();
        test_ring_abort();
        test_zero_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
